// File: rtl/axis_mac_array_if.sv
// AXI-Stream bundle for axis_mac_array: pixel/weight beat channel in, result matrix channel out.
interface axis_mac_array_if #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int WORD_WIDTH     = 8,
  parameter int WORD_WIDTH_ACC = 24,
  parameter int TUSER_WIDTH    = 8
);
  logic                                s_axis_tvalid;
  logic                                s_axis_tready;
  logic                                s_axis_tlast;
  logic [TUSER_WIDTH-1:0]              s_axis_tuser;
  logic [ROWS*WORD_WIDTH-1:0]          s_axis_tdata_pixels;
  logic [COLS*WORD_WIDTH-1:0]          s_axis_tdata_weights;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;
  logic [COLS*ROWS*WORD_WIDTH_ACC-1:0] m_axis_tdata;
  logic                                m_axis_tlast;
  logic [TUSER_WIDTH-1:0]              m_axis_tuser;

  modport slave (
    input  s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tdata_pixels, s_axis_tdata_weights,
    input  m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
  );

  modport master (
    output s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tdata_pixels, s_axis_tdata_weights,
    output m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/axis_mac_array.sv
// Streaming ROWS x COLS signed outer-product accumulator feeding a credit-guarded
// first-word-fall-through result FIFO.
module axis_mac_array #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int WORD_WIDTH     = 8,
  parameter int WORD_WIDTH_ACC = 24,
  parameter int TUSER_WIDTH    = 8,
  parameter int DEPTH          = 4,
  parameter int GROUP          = 4,
  parameter int SATURATE       = 0
) (
  input  logic            aclk,
  input  logic            areset,
  axis_mac_array_if.slave axis
);
  localparam int ELEMS = ROWS * COLS;
  localparam int PW    = 2 * WORD_WIDTH;
  localparam int ACC   = WORD_WIDTH_ACC;
  localparam int DW    = ELEMS * ACC;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1) + 1;
  localparam int GRP_W = (GROUP > 1) ? $clog2(GROUP) : 1;

  typedef logic signed [PW-1:0]  prod_t;
  typedef logic signed [ACC-1:0] acc_t;
  typedef logic signed [ACC:0]   sum_t;

  function automatic logic [PW-1:0] mul_word(input logic [WORD_WIDTH-1:0] a,
                                             input logic [WORD_WIDTH-1:0] b);
    prod_t ea;
    prod_t eb;
    ea = prod_t'($signed(a));
    eb = prod_t'($signed(b));
    return ea * eb;
  endfunction

  // One extra bit of headroom lets the clamp see the true sum before wrapping.
  function automatic logic [ACC-1:0] acc_add(input logic [ACC-1:0] a, input logic [PW-1:0] p);
    sum_t           sum;
    sum_t           max_v;
    sum_t           min_v;
    logic [ACC-1:0] res;
    sum   = sum_t'($signed(a)) + sum_t'($signed(p));
    max_v = {2'b00, {(ACC-1){1'b1}}};
    min_v = {2'b11, {(ACC-1){1'b0}}};
    if ((SATURATE != 0) && (sum > max_v)) begin
      res = max_v[ACC-1:0];
    end else if ((SATURATE != 0) && (sum < min_v)) begin
      res = min_v[ACC-1:0];
    end else begin
      res = sum[ACC-1:0];
    end
    return res;
  endfunction

  logic                   s_hs, push, pop, out_valid;
  logic [ELEMS*PW-1:0]    prod_d, prod_q;
  logic                   v1_d, v1_q, l1_d, l1_q, v2_d, v2_q, l2_d, l2_q;
  logic [TUSER_WIDTH-1:0] u1_d, u1_q, u2_d, u2_q;
  logic [DW-1:0]          acc_d, acc_q;
  logic                   first_d, first_q;
  logic [PTR_W-1:0]       wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]       count_d, count_q;
  logic [1:0]             inflight_d, inflight_q;
  logic [GRP_W-1:0]       grp_d, grp_q;
  logic                   tready_d, tready_q;
  logic [DW-1:0]          mem_data [DEPTH];
  logic [TUSER_WIDTH-1:0] mem_user [DEPTH];
  logic                   mem_last [DEPTH];

  assign s_hs      = axis.s_axis_tvalid & tready_q;
  assign push      = v2_q & l2_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & axis.m_axis_tready;

  // Stage 1: register the outer product of the accepted beat.
  always_comb begin
    prod_d = prod_q;
    v1_d   = s_hs;
    l1_d   = s_hs & axis.s_axis_tlast;
    if (s_hs) begin
      u1_d = axis.s_axis_tuser;
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          prod_d[(c*ROWS+r)*PW +: PW] =
            mul_word(axis.s_axis_tdata_pixels[r*WORD_WIDTH +: WORD_WIDTH],
                     axis.s_axis_tdata_weights[c*WORD_WIDTH +: WORD_WIDTH]);
        end
      end
    end else begin
      u1_d = u1_q;
    end
  end

  // Stage 2: first beat of a packet loads, later beats accumulate.
  always_comb begin
    acc_d = acc_q;
    v2_d  = v1_q;
    l2_d  = v1_q & l1_q;
    u2_d  = u1_q;
    if (v1_q) begin
      first_d = l1_q;
      for (int e = 0; e < ELEMS; e++) begin
        acc_d[e*ACC +: ACC] = first_q ? acc_t'($signed(prod_q[e*PW +: PW]))
                                      : acc_add(acc_q[e*ACC +: ACC], prod_q[e*PW +: PW]);
      end
    end else begin
      first_d = first_q;
    end
  end

  // FIFO pointers, occupancy, in-flight tlast credits and group position.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    grp_d    = grp_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      grp_d    = (grp_q == GRP_W'(GROUP - 1)) ? '0 : grp_q + GRP_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case ({s_hs & axis.s_axis_tlast, push})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
    // Every accepted tlast beat already owns a FIFO slot, so the FIFO never overflows.
    tready_d = (count_d + CNT_W'(inflight_d)) < CNT_W'(DEPTH);
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      prod_q     <= '0;
      v1_q       <= 1'b0;
      l1_q       <= 1'b0;
      u1_q       <= '0;
      acc_q      <= '0;
      first_q    <= 1'b1;
      v2_q       <= 1'b0;
      l2_q       <= 1'b0;
      u2_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 2'd0;
      grp_q      <= '0;
      tready_q   <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      v1_q       <= v1_d;
      l1_q       <= l1_d;
      u1_q       <= u1_d;
      acc_q      <= acc_d;
      first_q    <= first_d;
      v2_q       <= v2_d;
      l2_q       <= l2_d;
      u2_q       <= u2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      grp_q      <= grp_d;
      tready_q   <= tready_d;
    end
  end

  // Result storage; contents are only observable through a non-empty head.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= acc_q;
      mem_user[wr_ptr_q] <= u2_q;
      mem_last[wr_ptr_q] <= (grp_q == GRP_W'(GROUP - 1));
    end
  end

  assign axis.s_axis_tready = tready_q;
  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tdata  = out_valid ? mem_data[rd_ptr_q] : '0;
  assign axis.m_axis_tuser  = out_valid ? mem_user[rd_ptr_q] : '0;
  assign axis.m_axis_tlast  = out_valid & mem_last[rd_ptr_q];
endmodule

// File: tb/tb_axis_mac_array.sv
// Directed bench for axis_mac_array: latency, accumulation, lane mapping, backpressure,
// saturate/wrap, output grouping and mid-packet reset.
module tb_axis_mac_array;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axis_mac_array_if #(.WORD_WIDTH_ACC(24)) bus ();
  axis_mac_array_if #(.WORD_WIDTH_ACC(16)) bus_sat ();
  axis_mac_array_if #(.WORD_WIDTH_ACC(16)) bus_wrap ();

  axis_mac_array #(.WORD_WIDTH_ACC(24), .SATURATE(0)) u_dut  (.aclk(aclk), .areset(areset), .axis(bus));
  axis_mac_array #(.WORD_WIDTH_ACC(16), .SATURATE(1)) u_sat  (.aclk(aclk), .areset(areset), .axis(bus_sat));
  axis_mac_array #(.WORD_WIDTH_ACC(16), .SATURATE(0)) u_wrap (.aclk(aclk), .areset(areset), .axis(bus_wrap));

  // The narrow-accumulator instances see exactly the same stimulus as the main one.
  assign bus_sat.s_axis_tvalid         = bus.s_axis_tvalid;
  assign bus_sat.s_axis_tlast          = bus.s_axis_tlast;
  assign bus_sat.s_axis_tuser          = bus.s_axis_tuser;
  assign bus_sat.s_axis_tdata_pixels   = bus.s_axis_tdata_pixels;
  assign bus_sat.s_axis_tdata_weights  = bus.s_axis_tdata_weights;
  assign bus_sat.m_axis_tready         = bus.m_axis_tready;
  assign bus_wrap.s_axis_tvalid        = bus.s_axis_tvalid;
  assign bus_wrap.s_axis_tlast         = bus.s_axis_tlast;
  assign bus_wrap.s_axis_tuser         = bus.s_axis_tuser;
  assign bus_wrap.s_axis_tdata_pixels  = bus.s_axis_tdata_pixels;
  assign bus_wrap.s_axis_tdata_weights = bus.s_axis_tdata_weights;
  assign bus_wrap.m_axis_tready        = bus.m_axis_tready;

  int n_vec = 0;
  int n_err = 0;

  logic [383:0] got_data [$];
  logic [7:0]   got_user [$];
  logic         got_last [$];
  logic [255:0] sat_data [$];
  logic [255:0] wrap_data [$];

  // Handshake state at the falling edge equals the state at the next rising edge.
  always @(negedge aclk) begin
    if (!areset && bus.m_axis_tvalid && bus.m_axis_tready) begin
      got_data.push_back(bus.m_axis_tdata);
      got_user.push_back(bus.m_axis_tuser);
      got_last.push_back(bus.m_axis_tlast);
    end
    if (!areset && bus_sat.m_axis_tvalid && bus_sat.m_axis_tready) sat_data.push_back(bus_sat.m_axis_tdata);
    if (!areset && bus_wrap.m_axis_tvalid && bus_wrap.m_axis_tready) wrap_data.push_back(bus_wrap.m_axis_tdata);
  end

  task automatic check_vec(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [31:0] uni(input int v);
    return lanes(v, v, v, v);
  endfunction

  function automatic logic [383:0] rep24(input int v);
    logic [383:0] r;
    for (int i = 0; i < 16; i++) r[i*24 +: 24] = 24'(v);
    return r;
  endfunction

  function automatic logic [255:0] rep16(input int v);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(v);
    return r;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] pix, input logic [31:0] wts, input logic last,
                           input logic [7:0] user);
    int budget = 100;
    bus.s_axis_tvalid        = 1'b1;
    bus.s_axis_tdata_pixels  = pix;
    bus.s_axis_tdata_weights = wts;
    bus.s_axis_tlast         = last;
    bus.s_axis_tuser         = user;
    while (bus.s_axis_tready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check_vec("beat_accept", 384'(budget > 0), 384'(1));
    tick();
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic [383:0] exp_data,
                             input logic [7:0] exp_user, input logic exp_last);
    int budget = 200;
    while (got_data.size() == 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (got_data.size() == 0) begin
      check_vec({tag, "_timeout"}, 384'(0), 384'(1));
    end else begin
      check_vec({tag, "_data"}, got_data.pop_front(), exp_data);
      check_vec({tag, "_user"}, 384'(got_user.pop_front()), 384'(exp_user));
      check_vec({tag, "_last"}, 384'(got_last.pop_front()), 384'(exp_last));
    end
  endtask

  task automatic apply_reset();
    bus.s_axis_tvalid = 1'b0;
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [383:0] lane_exp;
    int           wv [4];
    int           budget;

    bus.s_axis_tvalid        = 1'b0;
    bus.s_axis_tlast         = 1'b0;
    bus.s_axis_tuser         = 8'h00;
    bus.s_axis_tdata_pixels  = 32'h0;
    bus.s_axis_tdata_weights = 32'h0;
    bus.m_axis_tready        = 1'b0;
    areset = 1'b1;
    repeat (3) tick();
    check_vec("rst_s_tready", 384'(bus.s_axis_tready), 384'(0));
    check_vec("rst_m_tvalid", 384'(bus.m_axis_tvalid), 384'(0));
    check_vec("rst_m_tdata",  bus.m_axis_tdata, 384'(0));
    check_vec("rst_m_tuser",  384'(bus.m_axis_tuser), 384'(0));
    check_vec("rst_m_tlast",  384'(bus.m_axis_tlast), 384'(0));
    areset = 1'b0;
    tick();
    check_vec("rel_s_tready", 384'(bus.s_axis_tready), 384'(1));

    // single-beat packet and its latency
    send_beat(uni(2), uni(3), 1'b1, 8'h5A);
    check_vec("t1_lat_t0", 384'(bus.m_axis_tvalid), 384'(0));
    tick();
    check_vec("t1_lat_t1", 384'(bus.m_axis_tvalid), 384'(0));
    tick();
    check_vec("t1_lat_t2", 384'(bus.m_axis_tvalid), 384'(1));
    check_vec("t1_head",   bus.m_axis_tdata, rep24(6));
    bus.m_axis_tready = 1'b1;
    take_result("t1", rep24(6), 8'h5A, 1'b0);

    // three-beat accumulation, nothing emitted before tlast
    send_beat(uni(1), uni(4), 1'b0, 8'h11);
    send_beat(uni(2), uni(4), 1'b0, 8'h22);
    repeat (3) begin
      tick();
      check_vec("t2_no_early", 384'(bus.m_axis_tvalid), 384'(0));
    end
    send_beat(uni(3), uni(4), 1'b1, 8'h33);
    take_result("t2", rep24(24), 8'h33, 1'b0);

    // distinct lane values check the [c][r] placement and signed products
    wv = '{1, -2, 3, -5};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) lane_exp[(c*4+r)*24 +: 24] = 24'((r + 1) * wv[c]);
    send_beat(lanes(1, 2, 3, 4), lanes(1, -2, 3, -5), 1'b1, 8'h7E);
    take_result("lanes", lane_exp, 8'h7E, 1'b0);

    // reset mid-packet with a buffered result pending
    bus.m_axis_tready = 1'b0;
    send_beat(uni(7), uni(7), 1'b1, 8'hC7);
    repeat (3) tick();
    check_vec("t6_buffered", 384'(bus.m_axis_tvalid), 384'(1));
    send_beat(uni(5), uni(5), 1'b0, 8'h55);
    bus.s_axis_tvalid       = 1'b1;
    bus.s_axis_tdata_pixels = uni(6);
    areset = 1'b1;
    tick();
    check_vec("t6_rst_tvalid", 384'(bus.m_axis_tvalid), 384'(0));
    check_vec("t6_rst_tdata",  bus.m_axis_tdata, 384'(0));
    check_vec("t6_rst_tuser",  384'(bus.m_axis_tuser), 384'(0));
    check_vec("t6_rst_tlast",  384'(bus.m_axis_tlast), 384'(0));
    check_vec("t6_rst_tready", 384'(bus.s_axis_tready), 384'(0));
    areset = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    tick();
    check_vec("t6_rel_tready", 384'(bus.s_axis_tready), 384'(1));
    send_beat(uni(2), uni(3), 1'b1, 8'h66);
    bus.m_axis_tready = 1'b1;
    take_result("t6", rep24(6), 8'h66, 1'b0);
    repeat (4) tick();
    check_vec("t6_no_stale", 384'(got_data.size()), 384'(0));

    // backpressure: four credits, then stall, then release
    bus.m_axis_tready = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++) send_beat(uni(k + 1), uni(3), 1'b1, 8'(8'h40 + k));
    check_vec("t3_full_tready", 384'(bus.s_axis_tready), 384'(0));
    repeat (4) tick();
    check_vec("t3_hold_tready", 384'(bus.s_axis_tready), 384'(0));
    check_vec("t3_hold_tvalid", 384'(bus.m_axis_tvalid), 384'(1));
    check_vec("t3_hold_head",   bus.m_axis_tdata, rep24(3));
    bus.m_axis_tready = 1'b1;
    send_beat(uni(5), uni(3), 1'b1, 8'h44);
    send_beat(uni(6), uni(3), 1'b1, 8'h45);
    for (int k = 0; k < 6; k++)
      take_result($sformatf("t3_r%0d", k), rep24(3 * (k + 1)), 8'(8'h40 + k), k == 3);

    // grouping with a toggling downstream ready
    bus.m_axis_tready = 1'b0;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          tick();
          bus.m_axis_tready = i[0];
        end
        bus.m_axis_tready = 1'b1;
      end
      begin
        for (int k = 0; k < 9; k++) send_beat(uni(k + 1), uni(-1), 1'b1, 8'(8'h80 + k));
      end
    join
    for (int k = 0; k < 9; k++)
      take_result($sformatf("t5_r%0d", k), rep24(-(k + 1)), 8'(8'h80 + k), (k == 3) || (k == 7));

    // saturation versus wrap on a 16-bit accumulator, full width for reference
    bus.m_axis_tready = 1'b1;
    apply_reset();
    sat_data.delete();
    wrap_data.delete();
    for (int k = 0; k < 3; k++) send_beat(uni(127), uni(127), k == 2, 8'hA1);
    for (int k = 0; k < 3; k++) send_beat(uni(-128), uni(127), k == 2, 8'hA2);
    take_result("t4_pos_acc24", rep24(48387), 8'hA1, 1'b0);
    take_result("t4_neg_acc24", rep24(-48768), 8'hA2, 1'b0);
    budget = 50;
    while ((sat_data.size() < 2 || wrap_data.size() < 2) && budget > 0) begin
      tick();
      budget--;
    end
    check_vec("t4_sat_cnt",  384'(sat_data.size()), 384'(2));
    check_vec("t4_wrap_cnt", 384'(wrap_data.size()), 384'(2));
    if (sat_data.size() == 2) begin
      check_vec("t4_sat_pos", 384'(sat_data.pop_front()), 384'(rep16(32767)));
      check_vec("t4_sat_neg", 384'(sat_data.pop_front()), 384'(rep16(-32768)));
    end
    if (wrap_data.size() == 2) begin
      check_vec("t4_wrap_pos", 384'(wrap_data.pop_front()), 384'(rep16(-17149)));
      check_vec("t4_wrap_neg", 384'(wrap_data.pop_front()), 384'(rep16(16768)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
